dmem_stage: RTL and testbench
=============================

Name: dmem_stage

Overview:
- MEM-stage data memory block of the pipelined CPU; consumes the 5-bit data-memory address chosen by the address mux in front of it.
- Holds a 32 x 32-bit data array.
- Executes one load or store per request through a small multi-cycle FSM.
- Holds the pipeline with a stall signal until the access completes.

Parameters:
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W words (32).
- DATA_W, 32, word width.
- LAT, 2, access latency in cycles spent in BUSY; legal range 1..15. Elaboration error outside that range.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  MEM-stage instruction is a load or store; held stable by the pipeline while stall=1.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address from the address mux.
- req_wdata  in  DATA_W  store data.
- stall  out  1  freezes the upstream pipeline registers.
- rdata  out  DATA_W  load result, registered.
- rdata_valid  out  1  one-cycle pulse; rdata holds a fresh load result.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- States: IDLE, BUSY, DONE; 4-bit down-counter cnt.
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0, rdata=0, rdata_valid=0, busy=0.
  - All DEPTH array words cleared to 0.
  - Latched request registers cleared.
- IDLE:
  - On req_valid=1, latch we, addr and wdata; set cnt<=LAT-1; go to BUSY.
  - On req_valid=0, stay in IDLE.
- BUSY:
  - While cnt!=0, decrement cnt.
  - When cnt==0 and latched store: mem[addr]<=wdata at that edge; go to DONE.
  - When cnt==0 and latched load: rdata<=mem[addr] at that edge; go to DONE.
- DONE:
  - rdata_valid=1 only if the access was a load.
  - Unconditionally go to IDLE; the pipeline advances at this edge.
- stall = req_valid & (state != DONE), combinational.
  - Asserted in the same cycle the request first appears in IDLE.
  - Deasserted only in DONE.
- Latency: request seen at IDLE edge N.
  - Write or read occurs at edge N+LAT.
  - DONE during cycle N+LAT; rdata valid in that cycle.
  - Throughput is one access per LAT+2 cycles.
- Latched address and data are used, so upstream changes during BUSY are ignored (a protocol violation in any case).
- req_valid dropping during BUSY: the access still completes; no abort.
- rdata retains its last load value until the next load. Stores never change rdata.
- Reset mid-operation: the pending store is discarded (no write) and the FSM returns to IDLE.
- Addresses wrap naturally; all 2**ADDR_W values are legal, so there is no out-of-range case.

Optional Feature:
- Macro: DMEM_STATS_EN.
- Defined:
  - Adds outputs load_cnt[15:0] and store_cnt[15:0], reset to 0.
  - Each increments on the BUSY->DONE edge for its access type.
  - Both saturate at 16'hFFFF.
- Undefined: ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Package dmem_pkg holds:
  - state encoding IDLE=2'd0, BUSY=2'd1, DONE=2'd2;
  - default ADDR_W/DATA_W constants;
  - counter width constant CNT_W=4.
- Sub-module dmem_array: DEPTH x DATA_W register array with async clear on rst_n, synchronous write enable, and synchronous registered read port. dmem_stage instantiates it and owns the FSM and stall logic.

Test Plan:
- Reset, then load addr 5 (LAT=2) -> stall=1 for 3 cycles, rdata_valid pulses once, rdata=32'h0.
- Store 32'hDEADBEEF to addr 31, then load addr 31 -> rdata=32'hDEADBEEF on the pulse; stores produce no rdata_valid pulse.
- Back-to-back store addr 0 = 32'h1 and load addr 0 with req_valid held high -> second request accepted the cycle after DONE; rdata=32'h1; 8 cycles total with LAT=2.
- Change req_addr from 3 to 4 during BUSY of a store of 32'hA5A5A5A5 -> mem[3]=32'hA5A5A5A5, mem[4] unchanged.
- Assert rst_n=0 in BUSY of a store of 32'h55 to addr 7 -> FSM back in IDLE; later load of addr 7 returns 0.
- LAT=1 build with DMEM_STATS_EN: 3 stores then 2 loads -> store_cnt=3, load_cnt=2; stall length 2 cycles per access.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data memory.
// State encoding, default widths and the latency counter width.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W register array: async clear, sync write, registered read.
// Ports: clk, rst_n, we/waddr/wdata write port, re/raddr/rdata read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        mem[waddr] <= wdata;
      end
      // rdata only moves on a load, so it holds across stores
      if (re) begin
        rdata <= mem[raddr];
      end
    end
  end

endmodule

// File: rtl/dmem_stage.sv
// MEM-stage data memory: multi-cycle load/store FSM with pipeline stall.
// Ports: clk, rst_n, req_* request, stall, rdata/rdata_valid, busy;
// load_cnt/store_cnt when built with DMEM_STATS_EN.
module dmem_stage
  import dmem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              busy
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]       load_cnt,
  output logic [15:0]       store_cnt
`endif
);

  if (LAT < 1 || LAT > 15) begin : g_bad_lat
    $error("dmem_stage: LAT must be in 1..15");
  end

  dmem_state_t       state;
  dmem_state_t       state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic is_idle;
  logic is_busy;
  logic is_done;
  logic fire;
  logic mem_we;
  logic mem_re;

  assign is_idle = (state == IDLE);
  assign is_busy = (state == BUSY);
  assign is_done = (state == DONE);
  assign fire    = is_busy & (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_nx;
      if (is_idle && req_valid) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        cnt       <= CNT_W'(LAT - 1);
      end else if (is_busy && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      is_idle: if (req_valid) state_nx = BUSY;
      is_busy: if (cnt == '0) state_nx = DONE;
      is_done: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy        = ~is_idle;
    stall       = req_valid & ~is_done;
    rdata_valid = is_done & ~lat_we;
    mem_we      = fire & lat_we;
    mem_re      = fire & ~lat_we;
  end

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (lat_addr),
    .wdata (lat_wdata),
    .re    (mem_re),
    .raddr (lat_addr),
    .rdata (rdata)
  );

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt  <= '0;
      store_cnt <= '0;
    end else begin
      if (mem_re && load_cnt != 16'hFFFF) begin
        load_cnt <= load_cnt + 16'd1;
      end
      if (mem_we && store_cnt != 16'hFFFF) begin
        store_cnt <= store_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_stage.sv
// Randomized self-checking bench for dmem_stage.
// Reference model: plain word array plus load/store counts.
module tb_dmem_stage;

`ifdef DMEM_STATS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        busy;
`ifdef DMEM_STATS_EN
  logic [15:0] load_cnt;
  logic [15:0] store_cnt;
`endif

  logic [31:0] mdl [32];
  logic [31:0] last_rd;
  int          n_ld;
  int          n_st;
  int          npass  = 0;
  int          ntotal = 0;

  always #5 clk = ~clk;

  dmem_stage #(.ADDR_W(5), .DATA_W(32), .LAT(LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .busy        (busy)
`ifdef DMEM_STATS_EN
    ,
    .load_cnt    (load_cnt),
    .store_cnt   (store_cnt)
`endif
  );

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    last_rd = '0;
    n_ld    = 0;
    n_st    = 0;
  endtask

  // One request: runs until the DONE cycle, then steps past its edge.
  task automatic access(input logic we, input logic [4:0] addr,
                        input logic [31:0] wd, input logic poke,
                        output int cyc);
    int stalls;
    bit done;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    stalls    = 0;
    done      = 1'b0;
    cyc       = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      cyc++;
      if (stall) begin
        stalls++;
        ntotal++;
        if (rdata_valid !== 1'b0)
          $display("FAIL rv_in_stall a=%0d got=%b want=0", addr, rdata_valid);
        else npass++;
        if (poke && stalls == 2) begin
          req_addr  = addr + 5'd1;
          req_wdata = ~wd;
        end
      end else begin
        done = 1'b1;
        ntotal++;
        if (stalls !== LAT + 1)
          $display("FAIL stall_len got=%0d want=%0d", stalls, LAT + 1);
        else npass++;
        ntotal++;
        if (busy !== 1'b1)
          $display("FAIL busy_done got=%b want=1", busy);
        else npass++;
        if (we) begin
          mdl[addr] = wd;
          n_st++;
          ntotal++;
          if (rdata_valid !== 1'b0)
            $display("FAIL st_rv a=%0d got=%b want=0", addr, rdata_valid);
          else npass++;
          ntotal++;
          if (rdata !== last_rd)
            $display("FAIL st_rdata_hold got=%h want=%h", rdata, last_rd);
          else npass++;
        end else begin
          n_ld++;
          last_rd = mdl[addr];
          ntotal++;
          if (rdata_valid !== 1'b1)
            $display("FAIL ld_rv a=%0d got=%b want=1", addr, rdata_valid);
          else npass++;
          ntotal++;
          if (rdata !== mdl[addr])
            $display("FAIL ld_data a=%0d got=%h want=%h", addr, rdata, mdl[addr]);
          else npass++;
        end
      end
    end
    if (!done) begin
      ntotal++;
      $display("FAIL access_timeout a=%0d got=stuck want=done", addr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = 5'($urandom);
    req_wdata = $urandom;
    @(negedge clk);
    ntotal++;
    if ({stall, busy, rdata_valid} !== 3'b000)
      $display("FAIL idle_flags got=%b want=000", {stall, busy, rdata_valid});
    else npass++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rst_n     = 1'b0;
    @(negedge clk);
    model_reset();
    ntotal++;
    if ({stall, busy, rdata_valid} !== 3'b000)
      $display("FAIL rst_flags got=%b want=000", {stall, busy, rdata_valid});
    else npass++;
    ntotal++;
    if (rdata !== 32'h0)
      $display("FAIL rst_rdata got=%h want=0", rdata);
    else npass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_first_load();
    int c;
    access(1'b0, 5'd5, 32'h0, 1'b0, c);
    idle_cycle();
  endtask

  task automatic test_store_load();
    int c;
    access(1'b1, 5'd31, 32'hDEADBEEF, 1'b0, c);
    idle_cycle();
    access(1'b0, 5'd31, 32'h0, 1'b0, c);
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    int c1;
    int c2;
    access(1'b1, 5'd0, 32'h1, 1'b0, c1);
    access(1'b0, 5'd0, 32'h0, 1'b0, c2);
    ntotal++;
    if (c1 + c2 !== 2 * (LAT + 2))
      $display("FAIL b2b_cycles got=%0d want=%0d", c1 + c2, 2 * (LAT + 2));
    else npass++;
    idle_cycle();
  endtask

  task automatic test_addr_change();
    int c;
    access(1'b1, 5'd4, 32'h12345678, 1'b0, c);
    access(1'b1, 5'd3, 32'hA5A5A5A5, 1'b1, c);
    access(1'b0, 5'd3, 32'h0, 1'b0, c);
    access(1'b0, 5'd4, 32'h0, 1'b0, c);
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    int c;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 5'd7;
    req_wdata = 32'h55;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    ntotal++;
    if (busy !== 1'b0)
      $display("FAIL rst_mid_busy got=%b want=0", busy);
    else npass++;
    req_valid = 1'b0;
    #1;
    ntotal++;
    if (stall !== 1'b0)
      $display("FAIL rst_mid_stall got=%b want=0", stall);
    else npass++;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    access(1'b0, 5'd7, 32'h0, 1'b0, c);
    idle_cycle();
  endtask

  task automatic test_random();
    int c;
    for (int i = 0; i < 40; i++) begin
      access(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
             1'($urandom), c);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    req_valid = 1'b0;
  endtask

`ifdef DMEM_STATS_EN
  task automatic test_stats();
    int c;
    do_reset();
    for (int i = 0; i < 3; i++)
      access(1'b1, 5'(i + 10), $urandom, 1'b0, c);
    for (int i = 0; i < 2; i++)
      access(1'b0, 5'(i + 10), 32'h0, 1'b0, c);
    idle_cycle();
    ntotal++;
    if (store_cnt !== 16'(n_st) || n_st != 3)
      $display("FAIL store_cnt got=%0d want=3", store_cnt);
    else npass++;
    ntotal++;
    if (load_cnt !== 16'(n_ld) || n_ld != 2)
      $display("FAIL load_cnt got=%0d want=2", load_cnt);
    else npass++;
  endtask
`endif

  initial begin
    test_reset();
    test_first_load();
    test_store_load();
    test_back_to_back();
    test_addr_change();
    test_reset_mid();
    test_random();
`ifdef DMEM_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
